// File: rtl/mem_stage_pkg.sv
// Shared types, strobe constants and decode helpers for the memory-access stage.
package mem_stage_pkg;

   typedef enum logic [3:0] {
      OpNone, OpLb, OpLh, OpLw, OpLbu, OpLhu, OpSb, OpSh, OpSw
   } mem_op_t;

   typedef enum logic [1:0] {
      StIdle, StLoadWait, StStoreWait, StResp
   } mem_state_t;

   localparam logic [3:0] StrbByte = 4'b0001;
   localparam logic [3:0] StrbHalf = 4'b0011;
   localparam logic [3:0] StrbWord = 4'b1111;

   function automatic logic is_load(input mem_op_t op);
      return op inside {OpLb, OpLh, OpLw, OpLbu, OpLhu};
   endfunction

   function automatic logic is_store(input mem_op_t op);
      return op inside {OpSb, OpSh, OpSw};
   endfunction

   // Natural-alignment violation for the access size.
   function automatic logic is_misaligned(input mem_op_t op, input logic [1:0] a);
      case (op)
         OpLh, OpLhu, OpSh: return a[0];
         OpLw, OpSw:        return a != 2'b00;
         default:           return 1'b0;
      endcase
   endfunction

   // Byte offset actually used: halfwords snap to a[1], words to lane 0.
   function automatic logic [1:0] eff_offset(input mem_op_t op, input logic [1:0] a);
      case (op)
         OpLh, OpLhu, OpSh: return {a[1], 1'b0};
         OpLw, OpSw:        return 2'b00;
         default:           return a;
      endcase
   endfunction

   function automatic logic [3:0] store_strb(input mem_op_t op, input logic [1:0] off);
      case (op)
         OpSb:    return StrbByte << off;
         OpSh:    return StrbHalf << off;
         OpSw:    return StrbWord;
         default: return 4'b0000;
      endcase
   endfunction

   // Replicate store data across every lane; the strobe picks the live one.
   function automatic logic [31:0] store_data(input mem_op_t op, input logic [31:0] d);
      case (op)
         OpSb:    return {4{d[7:0]}};
         OpSh:    return {2{d[15:0]}};
         default: return d;
      endcase
   endfunction

endpackage

// File: rtl/load_align.sv
// Load lane select and sign/zero extension (purely combinational).
module load_align
   import mem_stage_pkg::*;
(
   input  mem_op_t     op_i,
   input  logic [1:0]  offset_i,
   input  logic [31:0] rdata_i,
   output logic [31:0] data_o
);

   logic [7:0]  byte_sel;
   logic [15:0] half_sel;

   // Pick the addressed lane, then extend according to the load type.
   always_comb begin
      byte_sel = rdata_i[{offset_i, 3'b000} +: 8];
      half_sel = rdata_i[{offset_i[1], 4'b0000} +: 16];
      case (op_i)
         OpLb:    data_o = {{24{byte_sel[7]}}, byte_sel};
         OpLbu:   data_o = {24'h000000, byte_sel};
         OpLh:    data_o = {{16{half_sel[15]}}, half_sel};
         OpLhu:   data_o = {16'h0000, half_sel};
         default: data_o = rdata_i;
      endcase
   end

endmodule

// File: rtl/mem_access_stage.sv
// Pipeline MEM stage: accepts one EX op at a time, drives a simple RAM read/write
// handshake, returns load/ALU results to writeback and flags RAM timeouts.
// Optional: define MEM_MISALIGN_TRAP_EN to trap misaligned half/word accesses
// instead of silently aligning them down.
module mem_access_stage
   import mem_stage_pkg::*;
#(
   parameter int unsigned RAM_LATENCY_MAX = 16
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        ex_valid,
   output logic        ex_ready,
   input  mem_op_t     ex_op,
   input  logic [31:0] ex_addr,
   input  logic [31:0] ex_store_data,
   input  logic [4:0]  ex_rd_addr,
   input  logic        ex_rd_wr_en,
   output logic        ram_rd_en,
   output logic [31:0] ram_rd_addr,
   input  logic [31:0] ram_rd_data,
   input  logic        ram_rd_valid,
   output logic        ram_wr_en,
   output logic [31:0] ram_wr_addr,
   output logic [31:0] ram_wr_data,
   output logic [3:0]  ram_wr_strb,
   input  logic        ram_wr_ack,
   output logic        wb_valid,
   output logic        wb_wr_en,
   output logic [4:0]  wb_rd_addr,
   output logic [31:0] wb_rd_data,
   output logic        mem_fault
);

   localparam int unsigned CntW = $clog2(RAM_LATENCY_MAX + 1);
   localparam logic [CntW-1:0] LastCnt = CntW'(RAM_LATENCY_MAX - 1);
   localparam logic [CntW-1:0] CntOne  = CntW'(1);

   mem_state_t      state_q;
   mem_op_t         op_q;
   logic [1:0]      off_q;
   logic [4:0]      rd_addr_q;
   logic            rd_wr_en_q;
   logic [CntW-1:0] cnt_q;
   logic            ram_rd_en_q, ram_wr_en_q;
   logic [31:0]     ram_rd_addr_q, ram_wr_addr_q, ram_wr_data_q;
   logic [3:0]      ram_wr_strb_q;
   logic            wb_valid_q, wb_wr_en_q, mem_fault_q;
   logic [4:0]      wb_rd_addr_q;
   logic [31:0]     wb_rd_data_q;

   logic [1:0]      ex_off;
   logic            ex_trap;
   logic            rd_we_eff;
   logic [31:0]     load_data;

   assign ex_off    = eff_offset(ex_op, ex_addr[1:0]);
   assign rd_we_eff = rd_wr_en_q && (rd_addr_q != 5'd0);

`ifdef MEM_MISALIGN_TRAP_EN
   assign ex_trap = is_misaligned(ex_op, ex_addr[1:0]);
`else
   assign ex_trap = 1'b0;
`endif

   load_align u_load_align (
      .op_i     (op_q),
      .offset_i (off_q),
      .rdata_i  (ram_rd_data),
      .data_o   (load_data)
   );

   // Ready is held low for the whole time reset is high, even between clock edges.
   assign ex_ready = (state_q == StIdle) && !reset;

   // Stage FSM with all RAM/writeback/fault outputs registered.
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q       <= StIdle;
         op_q          <= OpNone;
         off_q         <= 2'b00;
         rd_addr_q     <= 5'd0;
         rd_wr_en_q    <= 1'b0;
         cnt_q         <= '0;
         ram_rd_en_q   <= 1'b0;
         ram_rd_addr_q <= 32'd0;
         ram_wr_en_q   <= 1'b0;
         ram_wr_addr_q <= 32'd0;
         ram_wr_data_q <= 32'd0;
         ram_wr_strb_q <= 4'b0000;
         wb_valid_q    <= 1'b0;
         wb_wr_en_q    <= 1'b0;
         wb_rd_addr_q  <= 5'd0;
         wb_rd_data_q  <= 32'd0;
         mem_fault_q   <= 1'b0;
      end else begin
         mem_fault_q <= 1'b0;
         unique case (state_q)
            StIdle: begin
               if (ex_valid) begin
                  op_q       <= ex_op;
                  off_q      <= ex_off;
                  rd_addr_q  <= ex_rd_addr;
                  rd_wr_en_q <= ex_rd_wr_en;
                  cnt_q      <= '0;
                  if (ex_trap) begin
                     mem_fault_q <= 1'b1;
                  end else if (is_load(ex_op)) begin
                     state_q       <= StLoadWait;
                     ram_rd_en_q   <= 1'b1;
                     ram_rd_addr_q <= {ex_addr[31:2], 2'b00};
                  end else if (is_store(ex_op)) begin
                     state_q       <= StStoreWait;
                     ram_wr_en_q   <= 1'b1;
                     ram_wr_addr_q <= {ex_addr[31:2], 2'b00};
                     ram_wr_data_q <= store_data(ex_op, ex_store_data);
                     ram_wr_strb_q <= store_strb(ex_op, ex_off);
                  end else begin
                     // NONE: pass the ALU result straight to writeback.
                     state_q      <= StResp;
                     wb_valid_q   <= 1'b1;
                     wb_wr_en_q   <= ex_rd_wr_en && (ex_rd_addr != 5'd0);
                     wb_rd_addr_q <= ex_rd_addr;
                     wb_rd_data_q <= ex_addr;
                  end
               end
            end
            StLoadWait: begin
               if (ram_rd_valid) begin
                  state_q       <= StResp;
                  ram_rd_en_q   <= 1'b0;
                  ram_rd_addr_q <= 32'd0;
                  wb_valid_q    <= 1'b1;
                  wb_wr_en_q    <= rd_we_eff;
                  wb_rd_addr_q  <= rd_addr_q;
                  wb_rd_data_q  <= load_data;
               end else if (cnt_q == LastCnt) begin
                  state_q       <= StIdle;
                  ram_rd_en_q   <= 1'b0;
                  ram_rd_addr_q <= 32'd0;
                  mem_fault_q   <= 1'b1;
                  cnt_q         <= '0;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            StStoreWait: begin
               if (ram_wr_ack || (cnt_q == LastCnt)) begin
                  state_q       <= StIdle;
                  ram_wr_en_q   <= 1'b0;
                  ram_wr_addr_q <= 32'd0;
                  ram_wr_data_q <= 32'd0;
                  ram_wr_strb_q <= 4'b0000;
                  mem_fault_q   <= !ram_wr_ack;
                  cnt_q         <= '0;
               end else begin
                  cnt_q <= cnt_q + CntOne;
               end
            end
            StResp: begin
               state_q      <= StIdle;
               wb_valid_q   <= 1'b0;
               wb_wr_en_q   <= 1'b0;
               wb_rd_addr_q <= 5'd0;
               wb_rd_data_q <= 32'd0;
            end
            default: state_q <= StIdle;
         endcase
      end
   end

   assign ram_rd_en   = ram_rd_en_q;
   assign ram_rd_addr = ram_rd_addr_q;
   assign ram_wr_en   = ram_wr_en_q;
   assign ram_wr_addr = ram_wr_addr_q;
   assign ram_wr_data = ram_wr_data_q;
   assign ram_wr_strb = ram_wr_strb_q;
   assign wb_valid    = wb_valid_q;
   assign wb_wr_en    = wb_wr_en_q;
   assign wb_rd_addr  = wb_rd_addr_q;
   assign wb_rd_data  = wb_rd_data_q;
   assign mem_fault   = mem_fault_q;

endmodule

// File: tb/tb_mem_access_stage.sv
// Scoreboard bench for mem_access_stage: directed ops push expected writebacks and
// faults; a negedge monitor pops and compares whatever the DUT presents.
module tb_mem_access_stage;
   import mem_stage_pkg::*;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        ex_valid = 1'b0;
   logic        ex_ready;
   mem_op_t     ex_op = OpNone;
   logic [31:0] ex_addr = 32'd0;
   logic [31:0] ex_store_data = 32'd0;
   logic [4:0]  ex_rd_addr = 5'd0;
   logic        ex_rd_wr_en = 1'b0;
   logic        ram_rd_en;
   logic [31:0] ram_rd_addr;
   logic [31:0] ram_rd_data = 32'd0;
   logic        ram_rd_valid = 1'b0;
   logic        ram_wr_en;
   logic [31:0] ram_wr_addr;
   logic [31:0] ram_wr_data;
   logic [3:0]  ram_wr_strb;
   logic        ram_wr_ack = 1'b0;
   logic        wb_valid;
   logic        wb_wr_en;
   logic [4:0]  wb_rd_addr;
   logic [31:0] wb_rd_data;
   logic        mem_fault;

   typedef struct packed {
      logic        wen;
      logic [4:0]  rd;
      logic [31:0] data;
   } wb_exp_t;

   wb_exp_t exp_q[$];
   int      exp_faults = 0;
   int      n_tests = 0;
   int      n_fail = 0;

   always #5 clk = ~clk;

   mem_access_stage #(.RAM_LATENCY_MAX(16)) dut (
      .clk           (clk),
      .reset         (reset),
      .ex_valid      (ex_valid),
      .ex_ready      (ex_ready),
      .ex_op         (ex_op),
      .ex_addr       (ex_addr),
      .ex_store_data (ex_store_data),
      .ex_rd_addr    (ex_rd_addr),
      .ex_rd_wr_en   (ex_rd_wr_en),
      .ram_rd_en     (ram_rd_en),
      .ram_rd_addr   (ram_rd_addr),
      .ram_rd_data   (ram_rd_data),
      .ram_rd_valid  (ram_rd_valid),
      .ram_wr_en     (ram_wr_en),
      .ram_wr_addr   (ram_wr_addr),
      .ram_wr_data   (ram_wr_data),
      .ram_wr_strb   (ram_wr_strb),
      .ram_wr_ack    (ram_wr_ack),
      .wb_valid      (wb_valid),
      .wb_wr_en      (wb_wr_en),
      .wb_rd_addr    (wb_rd_addr),
      .wb_rd_data    (wb_rd_data),
      .mem_fault     (mem_fault)
   );

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
      end
   endtask

   // Monitor: every wb_valid must match the oldest expectation; faults must be expected.
   initial forever begin
      @(negedge clk);
      if (wb_valid === 1'b1) begin
         if (exp_q.size() == 0) check("wb_unexpected", {63'd0, wb_valid}, 64'd0);
         else check("wb_data", {26'd0, wb_wr_en, wb_rd_addr, wb_rd_data}, {26'd0, exp_q.pop_front()});
      end
      if (mem_fault === 1'b1) begin
         if (exp_faults == 0) check("fault_unexpected", {63'd0, mem_fault}, 64'd0);
         else exp_faults--;
      end
   end

   // Call at a negedge; returns at the negedge of T+1.
   task automatic issue(input mem_op_t op, input logic [31:0] addr, input logic [31:0] data,
                        input logic [4:0] rd, input logic wen);
      int n = 0;
      while (ex_ready !== 1'b1 && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (ex_ready !== 1'b1) check("issue_ready_timeout", {63'd0, ex_ready}, 64'd1);
      ex_valid = 1'b1; ex_op = op; ex_addr = addr; ex_store_data = data;
      ex_rd_addr = rd; ex_rd_wr_en = wen;
      @(posedge clk);
      #1;
      ex_valid = 1'b0; ex_op = OpNone;
      @(negedge clk);
   endtask

   // Hold off ram_rd_valid for 'delay' cycles while checking the request is held.
   task automatic give_rd(input logic [31:0] d, input int delay, input logic [31:0] exp_addr);
      for (int i = 0; i <= delay; i++) begin
         check("rd_en_held", {63'd0, ram_rd_en}, 64'd1);
         check("rd_addr", {32'd0, ram_rd_addr}, {32'd0, exp_addr});
         if (i < delay) @(negedge clk);
      end
      ram_rd_valid = 1'b1; ram_rd_data = d;
      @(posedge clk);
      #1;
      ram_rd_valid = 1'b0;
      @(negedge clk);
      check("rd_en_drop", {63'd0, ram_rd_en}, 64'd0);
   endtask

   task automatic give_ack(input int delay, input logic [31:0] exp_addr,
                           input logic [31:0] exp_data, input logic [3:0] exp_strb);
      for (int i = 0; i <= delay; i++) begin
         check("wr_en_held", {63'd0, ram_wr_en}, 64'd1);
         check("wr_req", {28'd0, ram_wr_strb, ram_wr_addr},
               {28'd0, exp_strb, exp_addr});
         check("wr_data", {32'd0, ram_wr_data}, {32'd0, exp_data});
         if (i < delay) @(negedge clk);
      end
      ram_wr_ack = 1'b1;
      @(posedge clk);
      #1;
      ram_wr_ack = 1'b0;
      @(negedge clk);
      check("store_to_idle", {62'd0, ram_wr_en, ex_ready}, 64'd1);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation did not finish, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state
      repeat (2) @(negedge clk);
      check("reset_outs", {58'd0, ex_ready, ram_rd_en, ram_wr_en, wb_valid, wb_wr_en, mem_fault},
            64'd0);
      reset = 1'b0;
      #1;
      check("ready_after_reset", {63'd0, ex_ready}, 64'd1);
      @(negedge clk);

      // NONE -> writeback at T+1
      exp_q.push_back('{wen: 1'b1, rd: 5'd5, data: 32'h0000_1234});
      issue(OpNone, 32'h0000_1234, 32'd0, 5'd5, 1'b1);
      check("none_wb_t1", {62'd0, wb_valid, ex_ready}, 64'd2);
      @(negedge clk);
      check("none_resp_one_cycle", {62'd0, wb_valid, ex_ready}, 64'd1);

      // LB sign-extended, valid 3 cycles after the request
      exp_q.push_back('{wen: 1'b1, rd: 5'd7, data: 32'hFFFF_FF80});
      issue(OpLb, 32'h0000_0103, 32'd0, 5'd7, 1'b1);
      give_rd(32'h80FF_0000, 3, 32'h0000_0100);

      // LHU upper half, rd=0 suppresses the register write
      exp_q.push_back('{wen: 1'b0, rd: 5'd0, data: 32'h0000_8001});
      issue(OpLhu, 32'h0000_0302, 32'd0, 5'd0, 1'b1);
      give_rd(32'h8001_0000, 0, 32'h0000_0300);

      // LH lower half sign-extended
      exp_q.push_back('{wen: 1'b1, rd: 5'd2, data: 32'hFFFF_8000});
      issue(OpLh, 32'h0000_0100, 32'd0, 5'd2, 1'b1);
      give_rd(32'h1234_8000, 1, 32'h0000_0100);

      // LBU lane 0 zero-extended, write-enable off
      exp_q.push_back('{wen: 1'b0, rd: 5'd31, data: 32'h0000_00F0});
      issue(OpLbu, 32'h0000_0100, 32'd0, 5'd31, 1'b0);
      give_rd(32'h0000_00F0, 0, 32'h0000_0100);

      // SH to upper half, held until ack, no writeback
      issue(OpSh, 32'h0000_0102, 32'h0000_BEEF, 5'd3, 1'b1);
      give_ack(2, 32'h0000_0100, 32'hBEEF_BEEF, 4'b1100);

      // SB lane 1
      issue(OpSb, 32'h0000_0201, 32'h0000_00A5, 5'd3, 1'b1);
      give_ack(0, 32'h0000_0200, 32'hA5A5_A5A5, 4'b0010);

      // SW full word
      issue(OpSw, 32'h0000_0040, 32'hDEAD_BEEF, 5'd3, 1'b1);
      give_ack(1, 32'h0000_0040, 32'hDEAD_BEEF, 4'b1111);

      // Misaligned LW
`ifdef MEM_MISALIGN_TRAP_EN
      exp_faults++;
      issue(OpLw, 32'h0000_0101, 32'd0, 5'd9, 1'b1);
      check("misalign_trap", {61'd0, mem_fault, ram_rd_en, wb_valid}, 64'd4);
      @(negedge clk);
      check("misalign_pulse", {62'd0, mem_fault, ex_ready}, 64'd1);
`else
      exp_q.push_back('{wen: 1'b1, rd: 5'd9, data: 32'h1122_3344});
      issue(OpLw, 32'h0000_0101, 32'd0, 5'd9, 1'b1);
      check("misalign_no_fault", {63'd0, mem_fault}, 64'd0);
      give_rd(32'h1122_3344, 0, 32'h0000_0100);
`endif

      // Timeout: request held 16 cycles, then a fault pulse and back to IDLE
      exp_faults++;
      issue(OpLw, 32'h0000_0200, 32'd0, 5'd4, 1'b1);
      for (int i = 0; i < 16; i++) begin
         check("timeout_rd_held", {63'd0, ram_rd_en}, 64'd1);
         @(negedge clk);
      end
      check("timeout_fault", {61'd0, mem_fault, ex_ready, ram_rd_en}, 64'd6);
      // Late valid in IDLE must be ignored
      ram_rd_valid = 1'b1; ram_rd_data = 32'hCAFE_0000;
      @(negedge clk);
      ram_rd_valid = 1'b0;
      check("timeout_fault_one_cycle", {62'd0, mem_fault, ex_ready}, 64'd1);
      @(negedge clk);
      check("late_valid_ignored", {62'd0, wb_valid, ex_ready}, 64'd1);

      // Reset in the middle of LOAD_WAIT, then a late ram_rd_valid
      issue(OpLw, 32'h0000_0300, 32'd0, 5'd6, 1'b1);
      @(negedge clk);
      reset = 1'b1;
      #1;
      check("midreset_outs", {59'd0, ex_ready, ram_rd_en, ram_wr_en, wb_valid, mem_fault}, 64'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("midreset_ready", {63'd0, ex_ready}, 64'd1);
      ram_rd_valid = 1'b1; ram_rd_data = 32'h5555_AAAA;
      @(posedge clk);
      #1;
      ram_rd_valid = 1'b0;
      @(negedge clk);
      check("midreset_no_wb", {61'd0, wb_valid, ram_rd_en, mem_fault}, 64'd0);
      // Stray ack in IDLE
      ram_wr_ack = 1'b1;
      @(negedge clk);
      ram_wr_ack = 1'b0;
      check("stray_ack_ignored", {62'd0, ram_wr_en, ex_ready}, 64'd1);

      repeat (3) @(negedge clk);
      check("wb_pending", 64'(exp_q.size()), 64'd0);
      check("fault_pending", 64'(exp_faults), 64'd0);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
